// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
//   Multi-cycle radix-2 multiply/divide unit. It runs one operation at a time
//   behind a start/ready/valid handshake. Multiplies use shift-add and divides
//   use a restoring algorithm, both one bit per cycle. Signed operations work on
//   magnitudes, and the final sign is applied in a single fix-up cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request, accepted only while ready=1
//   op         000 MUL, 001 UMULL, 010 SMULL, 011 UDIV, 100 SDIV (others illegal)
//   a, b       multiplicand/multiplier or dividend/divisor
//   ready      high while idle
//   valid      one-cycle pulse when results/flags are updated
//   result_lo  product low word or quotient
//   result_hi  product high word, remainder, or 0 for MUL
//   flags      {N,Z,C,V}, where C and V are always 0
//   div_zero   set with valid for a divide by zero, cleared by the next accepted start
module iter_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div_zero
);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b011;
    localparam logic [2:0] OP_SDIV  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;       // {partial product/remainder, multiplier/quotient}
    logic                 neg_lo_q, neg_lo_d; // negate product or quotient
    logic                 neg_hi_q, neg_hi_d; // negate remainder
    logic                 dz_q, dz_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic [3:0]           flags_q, flags_d;
    logic                 div_zero_q, div_zero_d;

    // Decode of the incoming request
    logic             in_signed, in_mul, in_div, in_legal;
    logic [WIDTH-1:0] a_abs, b_abs;

    // One-bit iteration datapaths
    logic               is_mul_q;
    logic [WIDTH:0]     mul_sum, mul_upper;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot_neg, rem_neg;

    always_comb begin
        in_signed = (op == OP_SMULL) || (op == OP_SDIV);
        in_mul    = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
        in_div    = (op == OP_UDIV) || (op == OP_SDIV);
        in_legal  = in_mul || in_div;
        a_abs     = (in_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (in_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        is_mul_q = (op_q == OP_MUL) || (op_q == OP_UMULL) || (op_q == OP_SMULL);

        // Shift-add: add the multiplicand into the upper half when the multiplier
        // LSB is set. The carry moves into the MSB on the right shift.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_upper = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        mul_next  = {mul_upper, acc_q[WIDTH-1:1]};

        // Restoring divide: the dividend bits shift out of the low half as the
        // quotient bits shift in.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_neg = -acc_q;
        quot_neg = -acc_q[WIDTH-1:0];
        rem_neg  = -acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        valid_d    = 1'b0;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        flags_d    = flags_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    div_zero_d = 1'b0;
                    dz_d       = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                    neg_lo_d   = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_hi_d   = (op == OP_SDIV) && a[WIDTH-1];
                    if (in_mul) begin
                        opnd_d = a_abs;
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                    end else begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                    end
                    if (!in_legal) begin
                        res_lo_d = '0;
                        res_hi_d = '0;
                        state_d  = S_DONE;
                    end else if (in_div && (b == '0)) begin
                        res_lo_d = '1;
                        res_hi_d = a;
                        dz_d     = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = is_mul_q ? mul_next : div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL: begin
                        res_lo_d = acc_q[WIDTH-1:0];
                        res_hi_d = '0;
                    end
                    OP_UMULL: begin
                        res_lo_d = acc_q[WIDTH-1:0];
                        res_hi_d = acc_q[2*WIDTH-1:WIDTH];
                    end
                    OP_SMULL: begin
                        res_lo_d = neg_lo_q ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        res_hi_d = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH]
                                            : acc_q[2*WIDTH-1:WIDTH];
                    end
                    OP_UDIV: begin
                        res_lo_d = acc_q[WIDTH-1:0];
                        res_hi_d = acc_q[2*WIDTH-1:WIDTH];
                    end
                    OP_SDIV: begin
                        res_lo_d = neg_lo_q ? quot_neg : acc_q[WIDTH-1:0];
                        res_hi_d = neg_hi_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
                    end
                    default: begin
                        res_lo_d = '0;
                        res_hi_d = '0;
                    end
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                valid_d    = 1'b1;
                div_zero_d = dz_q;
                if ((op_q == OP_UMULL) || (op_q == OP_SMULL)) begin
                    flags_d = {res_hi_q[WIDTH-1], (res_hi_q == '0) && (res_lo_q == '0), 2'b00};
                end else begin
                    flags_d = {res_lo_q[WIDTH-1], (res_lo_q == '0), 2'b00};
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            valid_q    <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            flags_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            valid_q    <= valid_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            flags_q    <= flags_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign valid     = valid_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign flags     = flags_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed bench for iter_muldiv_unit at WIDTH=32. It drives inputs on falling
// edges and samples outputs on falling edges.
module tb_iter_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready, valid, div_zero;
    logic [W-1:0]  result_lo, result_hi;
    logic [3:0]    flags;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int vpulses = 0;
    int lat;
    int p0;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .valid(valid), .result_lo(result_lo), .result_hi(result_hi),
        .flags(flags), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid) vpulses++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge. Returns on the falling edge after the accepting rising edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("ready_wait", 64'(ready), 64'd1);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 3'(($urandom_range(0, 7)));
        a = $urandom;
        b = $urandom;
        acc_cyc = cyc;
    endtask

    // Returns the number of rising edges from acceptance until valid is seen (bounded).
    task automatic wait_valid(output int l);
        int n = 0;
        while (!valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        l = cyc - acc_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        #1;
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_lo", 64'(result_lo), 64'd0);
        check_eq("rst_hi", 64'(result_hi), 64'd0);
        check_eq("rst_flags", 64'(flags), 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 64'(ready), 64'd1);

        // SMULL -3 * 5
        start_op(3'b010, 32'hFFFFFFFD, 32'd5);
        wait_valid(lat);
        check_eq("smull_lat", 64'(lat), 64'd34);
        check_eq("smull_lo", 64'(result_lo), 64'hFFFFFFF1);
        check_eq("smull_hi", 64'(result_hi), 64'hFFFFFFFF);
        check_eq("smull_flags", 64'(flags), 64'b1000);
        check_eq("smull_ready", 64'(ready), 64'd1);
        @(negedge clk);
        check_eq("valid_pulse", 64'(valid), 64'd0);
        check_eq("hold_lo", 64'(result_lo), 64'hFFFFFFF1);

        // UMULL max * max: the high word 0xFFFFFFFE has its MSB set, so N=1
        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(lat);
        check_eq("umull_lat", 64'(lat), 64'd34);
        check_eq("umull_lo", 64'(result_lo), 64'h00000001);
        check_eq("umull_hi", 64'(result_hi), 64'hFFFFFFFE);
        check_eq("umull_flags", 64'(flags), 64'b1000);

        start_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(lat);
        check_eq("mul_lo", 64'(result_lo), 64'd1);
        check_eq("mul_hi", 64'(result_hi), 64'd0);
        check_eq("mul_flags", 64'(flags), 64'b0000);

        start_op(3'b011, 32'd100, 32'd7);
        wait_valid(lat);
        check_eq("udiv_lat", 64'(lat), 64'd34);
        check_eq("udiv_lo", 64'(result_lo), 64'd14);
        check_eq("udiv_hi", 64'(result_hi), 64'd2);
        check_eq("udiv_flags", 64'(flags), 64'b0000);

        start_op(3'b100, 32'hFFFFFFF9, 32'd2);
        wait_valid(lat);
        check_eq("sdiv_lo", 64'(result_lo), 64'hFFFFFFFD);
        check_eq("sdiv_hi", 64'(result_hi), 64'hFFFFFFFF);
        check_eq("sdiv_flags", 64'(flags), 64'b1000);

        start_op(3'b100, 32'h80000000, 32'hFFFFFFFF);
        wait_valid(lat);
        check_eq("sdiv_min_lo", 64'(result_lo), 64'h80000000);
        check_eq("sdiv_min_hi", 64'(result_hi), 64'd0);
        check_eq("sdiv_min_dz", 64'(div_zero), 64'd0);
        check_eq("sdiv_min_flags", 64'(flags), 64'b1000);

        // Divide by zero
        start_op(3'b011, 32'h00001234, 32'd0);
        wait_valid(lat);
        check_eq("dz_lat", 64'(lat), 64'd1);
        check_eq("dz_lo", 64'(result_lo), 64'hFFFFFFFF);
        check_eq("dz_hi", 64'(result_hi), 64'h00001234);
        check_eq("dz_flag", 64'(div_zero), 64'd1);
        check_eq("dz_flags", 64'(flags), 64'b1000);

        // Start while busy is ignored, then a back-to-back start in the valid cycle
        start_op(3'b001, 32'd6, 32'd7);
        check_eq("dz_clear", 64'(div_zero), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("busy_ready", 64'(ready), 64'd0);
        op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat);
        check_eq("ign_lat", 64'(lat), 64'd34);
        check_eq("ign_lo", 64'(result_lo), 64'd42);
        check_eq("ign_hi", 64'(result_hi), 64'd0);
        start_op(3'b011, 32'd1000, 32'd10);
        wait_valid(lat);
        check_eq("b2b_lat", 64'(lat), 64'd34);
        check_eq("b2b_lo", 64'(result_lo), 64'd100);
        check_eq("b2b_hi", 64'(result_hi), 64'd0);

        // Asynchronous reset in the middle of an SMULL
        start_op(3'b010, 32'hFFFFFFFD, 32'd5);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_lo", 64'(result_lo), 64'd0);
        check_eq("arst_hi", 64'(result_hi), 64'd0);
        check_eq("arst_valid", 64'(valid), 64'd0);
        check_eq("arst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("arst_ready", 64'(ready), 64'd1);
        p0 = vpulses;
        repeat (40) @(negedge clk);
        check_eq("arst_no_valid", 64'(vpulses - p0), 64'd0);

        // Illegal op
        start_op(3'b111, 32'd5, 32'd9);
        wait_valid(lat);
        check_eq("ill_lat", 64'(lat), 64'd1);
        check_eq("ill_lo", 64'(result_lo), 64'd0);
        check_eq("ill_hi", 64'(result_hi), 64'd0);
        check_eq("ill_flags", 64'(flags), 64'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
